// File: rtl/alu_result_log_if.sv
// Bundle of the ALU result log's key inputs, result bus and display outputs.
// There is no valid/ready handshake here: STORE, NEXT and CLEAR are raw key
// levels, and only their rising edges matter (synchronized and edge-detected
// inside the log). RESULT is sampled on the cycle a store takes effect.
// The display outputs are plain register-derived levels with no qualifier.
interface alu_result_log_if #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] RESULT;
  logic             STORE;
  logic             NEXT;
  logic             CLEAR;
  logic [WIDTH-1:0] VIEW;
  logic [AW-1:0]    VIEW_IDX;
  logic [AW:0]      COUNT;
  logic             FULL;
  logic             EMPTY;

  // Board / ALU side: drives the keys and result, watches the display.
  modport master (
    output RESULT, STORE, NEXT, CLEAR,
    input  VIEW, VIEW_IDX, COUNT, FULL, EMPTY
  );

  // Log side.
  modport slave (
    input  RESULT, STORE, NEXT, CLEAR,
    output VIEW, VIEW_IDX, COUNT, FULL, EMPTY
  );
endinterface

// File: rtl/alu_result_log.sv
// Circular log of the last DEPTH ALU results, scrollable oldest-to-newest.
// Keys are raw board levels: each goes through a two-flop synchronizer and a
// previous-value flop, giving a one-cycle pulse per rising edge.
// Per-cycle event priority is CLEAR, then STORE, then NEXT; lower-priority
// pulses arriving in the same cycle are dropped.
module alu_result_log #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic             CLOCK_50,
  input  logic             RESETN,
  alu_result_log_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] LAST_OFF = AW'(DEPTH - 1);

  // Key vector order: bit 0 STORE, bit 1 NEXT, bit 2 CLEAR.
  logic [2:0] key_lvl;
  logic [2:0] key_s1;
  logic [2:0] key_s2;
  logic [2:0] key_p;
  logic [2:0] key_pulse;

  logic             st_pulse;
  logic             nx_pulse;
  logic             cl_pulse;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic [AW:0]      count;
  logic [AW-1:0]    view_off;
  logic [AW-1:0]    view_phys;
  logic [AW:0]      view_next;
  logic             is_full;
  logic             is_empty;
  logic             do_store;

  assign key_lvl = {bus.CLEAR, bus.NEXT, bus.STORE};

  // Synchronize raw key levels and keep the previous synchronized value.
  always_ff @(posedge CLOCK_50 or negedge RESETN) begin
    if (!RESETN) begin
      key_s1 <= '0;
      key_s2 <= '0;
      key_p  <= '0;
    end else begin
      key_s1 <= key_lvl;
      key_s2 <= key_s1;
      key_p  <= key_s2;
    end
  end

  assign key_pulse = key_s2 & ~key_p;
  assign st_pulse  = key_pulse[0];
  assign nx_pulse  = key_pulse[1];
  assign cl_pulse  = key_pulse[2];

  assign is_full   = (count == FULL_CNT);
  assign is_empty  = (count == '0);
  assign do_store  = st_pulse & ~cl_pulse;

  // Decode the physical slot being viewed and the candidate scroll offset.
  always_comb begin
    view_phys = rd_ptr + view_off;
    view_next = {1'b0, view_off} + 1'b1;
  end

  // Pointer, count and view-offset update with CLEAR > STORE > NEXT priority.
  always_ff @(posedge CLOCK_50 or negedge RESETN) begin
    if (!RESETN) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      view_off <= '0;
    end else if (cl_pulse) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      view_off <= '0;
    end else if (st_pulse) begin
      wr_ptr <= wr_ptr + 1'b1;
      if (is_full) begin
        // Overwrite the oldest entry: the window slides forward by one.
        rd_ptr   <= rd_ptr + 1'b1;
        view_off <= LAST_OFF;
      end else begin
        count    <= count + 1'b1;
        view_off <= count[AW-1:0];
      end
    end else if (nx_pulse && !is_empty) begin
      // Wrap from the newest entry back to the oldest.
      if (view_next == count) begin
        view_off <= '0;
      end else begin
        view_off <= view_next[AW-1:0];
      end
    end
  end

  // Result storage; cleared on reset, untouched by CLEAR.
  always_ff @(posedge CLOCK_50 or negedge RESETN) begin
    if (!RESETN) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (do_store) begin
      mem[wr_ptr] <= bus.RESULT;
    end
  end

  // Display outputs are combinational from the registered state.
  always_comb begin
    bus.VIEW     = is_empty ? '0 : mem[view_phys];
    bus.VIEW_IDX = view_off;
    bus.COUNT    = count;
    bus.FULL     = is_full;
    bus.EMPTY    = is_empty;
  end
endmodule

// File: doc/alu_result_log.md
# alu_result_log

Circular result log placed directly downstream of the board ALU. It captures the ALU's 8-bit result each time the operator presses a store key, keeps the last DEPTH results, and lets the operator scroll through them oldest-to-newest for display on LEDR/HEX. Key inputs are raw board levels, so the block synchronizes them and edge-detects them internally.

## Interface
- DEPTH, 8: number of log entries; power of two, at least 2.
- WIDTH, 8: result width; matches the ALU output.
- CLOCK_50  in  1  system clock; all state changes on its rising edge.
- RESETN  in  1  reset; asynchronous and active-low.
- RESULT  in  WIDTH  ALU result bus; sampled only on the store event.
- STORE  in  1  raw key level, active-high; a rising edge appends RESULT.
- NEXT  in  1  raw key level, active-high; a rising edge advances the view.
- CLEAR  in  1  raw key level, active-high; a rising edge empties the log.
- VIEW  out  WIDTH  entry currently viewed; 0 when the log is empty.
- VIEW_IDX  out  log2(DEPTH)  age position of the viewed entry; 0 = oldest.
- COUNT  out  log2(DEPTH)+1  number of valid entries, 0..DEPTH.
- FULL  out  1  COUNT == DEPTH.
- EMPTY  out  1  COUNT == 0.

## Operation
- Each of STORE, NEXT and CLEAR uses a two-flop synchronizer (s1, s2) and a previous-value flop (p).
- An event pulse equals s2 & ~p. The pulse lasts exactly one cycle per rising edge of the input, no matter how long the key is held.
- Internal state:
  - mem[DEPTH] of WIDTH bits
  - rd_ptr: physical index of the oldest entry
  - wr_ptr: next write index
  - count
  - view_off: offset from rd_ptr
- Event priority per cycle: CLEAR, then STORE, then NEXT. Lower-priority pulses in the same cycle are dropped, not queued.
- CLEAR: rd_ptr = wr_ptr = count = view_off = 0. mem contents are left as they are but become invisible.
- STORE, not full:
  - mem[wr_ptr] = RESULT
  - wr_ptr+1 mod DEPTH
  - count+1
  - view_off = old count, so the view jumps to the newest entry
- STORE, full (overwrite oldest):
  - mem[wr_ptr] = RESULT
  - wr_ptr+1 and rd_ptr+1, both mod DEPTH
  - count stays DEPTH
  - view_off = DEPTH-1
- NEXT, count > 0: view_off = 0 if view_off+1 == count, otherwise view_off+1. This wraps from newest back to oldest.
- NEXT, count == 0: ignored.
- Outputs:
  - VIEW = count==0 ? 0 : mem[(rd_ptr+view_off) mod DEPTH], combinational from registers.
  - VIEW_IDX = view_off.
  - FULL, EMPTY and COUNT are combinational from count.
- Pointer arithmetic is modulo DEPTH (natural wrap of log2(DEPTH)-bit counters). count never exceeds DEPTH.

## Timing
- Reset (RESETN low, asynchronous):
  - all sync and edge flops, pointers, count, view_off = 0
  - mem zeroed
  - outputs: VIEW=0, VIEW_IDX=0, COUNT=0, EMPTY=1, FULL=0
- Reset is held for as long as RESETN is low. Release is synchronous to the next clock edge. An event whose input rose before release is detected only if the level is still high after release; it then counts as a new rising edge, because p=0.
- Latency: an input first sampled high at edge n gives s2 high after edge n+1. The pulse is high from n+1 to n+2, and the state update and new outputs appear after edge n+2.
- RESULT is captured at edge n+2. It must be stable one cycle before that edge, which is guaranteed because the ALU is combinational from switches.
- Back-to-back events need the input low for at least 2 cycles between rising edges.
- Reset during an event in flight discards the event.

## Test plan
- Reset, then 3 STOREs with RESULT=0x11, 0x22, 0x33 -> COUNT=3, VIEW=0x33, VIEW_IDX=2, EMPTY=0, FULL=0.
- From the previous state, 3 NEXTs -> VIEW goes 0x11, 0x22, 0x33, with VIEW_IDX 0, 1, 2 (wrap).
- 10 STOREs with values 0x01..0x0A (DEPTH=8) -> FULL=1, COUNT=8, VIEW=0x0A. One NEXT -> VIEW=0x03, VIEW_IDX=0, proving the oldest two entries were overwritten.
- STORE held high for 50 cycles -> exactly one entry added. Update observed exactly 2 edges after the first sampling edge.
- CLEAR and STORE rising together with RESULT=0x55 -> COUNT=0, EMPTY=1, VIEW=0. A NEXT on the empty log -> no change.
- RESETN pulsed low mid-log (COUNT=5) between clock edges -> outputs return to reset values immediately, without waiting for a clock edge.
